// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial sequencer driving one external full-adder cell.
// Optional feature macro: OVERFLOW_DETECT_EN (adds the ovf output).
//
// Ports:
//   clk, reset      rising-edge clock; asynchronous active-high reset
//   start, a, b, ci new add request with operands and carry-in, sampled on clk
//   fa_a/fa_b/fa_ci bit pair and carry presented to the cell, LSB first
//   fa_s/fa_co      sum and carry returned by the cell (combinational path)
//   busy            high while bits are being shifted through the cell
//   done            one-cycle pulse when sum/co are final
//   sum, co         result word and final carry, held until the next add
//   ovf             (OVERFLOW_DETECT_EN) signed overflow, held with sum
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_ci,
    input  logic             fa_s,
    input  logic             fa_co,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co
`ifdef OVERFLOW_DETECT_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0] areg, breg;
    logic [WIDTH-1:0] areg_nx, breg_nx, sum_nx;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             shifting;
    logic             last;
    logic             load;

    assign shifting = (state == SHIFT);
    assign busy     = shifting;
    assign done     = (state == DONE);
    assign last     = shifting && (cnt == LAST);
    // Start is only honoured when no add is in flight.
    assign load     = !shifting && start;

    // The cell inputs come straight from flops; outside SHIFT they are
    // forced low so the leftover carry never reaches the cell.
    assign fa_a  = shifting & areg[0];
    assign fa_b  = shifting & breg[0];
    assign fa_ci = shifting & carry;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = SHIFT;
            SHIFT:   if (cnt == LAST) state_nx = DONE;
            DONE:    state_nx = start ? SHIFT : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Right shifts written so WIDTH=1 needs no special case.
    always_comb begin
        areg_nx = areg >> 1;
        breg_nx = breg >> 1;
        sum_nx  = sum >> 1;
        sum_nx[WIDTH-1] = fa_s;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            areg  <= '0;
            breg  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            co    <= 1'b0;
`ifdef OVERFLOW_DETECT_EN
            ovf   <= 1'b0;
`endif
        end else if (load) begin
            areg  <= a;
            breg  <= b;
            carry <= ci;
            cnt   <= '0;
        end else if (shifting) begin
            areg  <= areg_nx;
            breg  <= breg_nx;
            sum   <= sum_nx;
            carry <= fa_co;
            cnt   <= cnt + CW'(1);
            if (last) begin
                co <= fa_co;
`ifdef OVERFLOW_DETECT_EN
                // Carry into MSB differs from carry out of MSB.
                ovf <= fa_ci ^ fa_co;
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed bench for serial_add_ctrl with a model
// full-adder cell; WIDTH=8, 100 ns clock.
module tb_serial_add_ctrl;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic       fa_a, fa_b, fa_ci;
    logic       fa_s, fa_co;
    logic       busy, done;
    logic [7:0] sum;
    logic       co;
`ifdef OVERFLOW_DETECT_EN
    logic       ovf;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .ci    (ci),
        .fa_a  (fa_a),
        .fa_b  (fa_b),
        .fa_ci (fa_ci),
        .fa_s  (fa_s),
        .fa_co (fa_co),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .co    (co)
`ifdef OVERFLOW_DETECT_EN
        ,
        .ovf   (ovf)
`endif
    );

    // Full-adder cell.
    assign fa_s  = fa_a ^ fa_b ^ fa_ci;
    assign fa_co = (fa_a & fa_b) | (fa_a & fa_ci) | (fa_b & fa_ci);

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic run_add(input string tag, input logic [7:0] ta,
                           input logic [7:0] tb_v, input logic tci,
                           input logic [7:0] es, input logic eco);
        int n;
        @(negedge clk);
        a = ta; b = tb_v; ci = tci; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        chk({tag, "_fa0"}, {29'd0, fa_a, fa_b, fa_ci},
            {29'd0, ta[0], tb_v[0], tci});
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, n, 9);
        chk({tag, "_sum"}, {24'd0, sum}, {24'd0, es});
        chk({tag, "_co"}, {31'd0, co}, {31'd0, eco});
        @(negedge clk);
        chk({tag, "_idle"}, {27'd0, busy, done, fa_a, fa_b, fa_ci}, 0);
    endtask

    initial begin
        int n, dcnt, dn;
        logic [7:0] ds;

        reset = 1'b0; start = 1'b0; a = '0; b = '0; ci = 1'b0;
        #5 reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ctl", {26'd0, busy, done, co, fa_a, fa_b, fa_ci}, 0);
        chk("rst_sum", {24'd0, sum}, 0);
        reset = 1'b0;

        run_add("basic", 8'h05, 8'h03, 1'b0, 8'h08, 1'b0);
        run_add("wrap", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        run_add("full", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        run_add("cin", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0);

        // Back-to-back: new start accepted in the DONE cycle.
        @(negedge clk);
        a = 8'h21; b = 8'h13; ci = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_lat1", n, 9);
        chk("b2b_sum1", {24'd0, sum}, 32'h34);
        a = 8'h10; b = 8'h20; ci = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_noidle", {31'd0, busy}, 1);
        n = 1;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_lat2", n, 9);
        chk("b2b_sum2", {24'd0, sum}, 32'h30);
        chk("b2b_co2", {31'd0, co}, 0);
        @(negedge clk);

        // Start pulse while busy must be ignored.
        a = 8'h12; b = 8'h34; ci = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        repeat (2) begin
            @(negedge clk);
            n++;
        end
        a = 8'hAA; b = 8'hAA; ci = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n++;
        dcnt = 0; dn = 0; ds = '0;
        while (n < 25) begin
            if (done) begin
                dcnt++;
                if (dn == 0) begin
                    dn = n;
                    ds = sum;
                end
            end
            @(negedge clk);
            n++;
        end
        chk("busy_lat", dn, 9);
        chk("busy_npulse", dcnt, 1);
        chk("busy_sum", {24'd0, ds}, 32'h46);

        // Reset three cycles into SHIFT.
        a = 8'h55; b = 8'h0F; ci = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_busy", {31'd0, busy}, 1);
        reset = 1'b1;
        #1;
        chk("mid_ctl", {26'd0, busy, done, co, fa_a, fa_b, fa_ci}, 0);
        chk("mid_sum", {24'd0, sum}, 0);
        dcnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        reset = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("mid_nodone", dcnt, 0);
        run_add("fresh", 8'h3C, 8'h42, 1'b1, 8'h7F, 1'b0);

        // Signed-overflow vectors.
        run_add("ov1", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);
`ifdef OVERFLOW_DETECT_EN
        chk("ov1_ovf", {31'd0, ovf}, 1);
`endif
        run_add("ov2", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
`ifdef OVERFLOW_DETECT_EN
        chk("ov2_ovf", {31'd0, ovf}, 1);
`endif
        run_add("ov3", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);
`ifdef OVERFLOW_DETECT_EN
        chk("ov3_ovf", {31'd0, ovf}, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
